// File: rtl/dma_pkg.sv
// Shared types for the DMA sequencer and its address generator:
// decoded address-control commands and the generator's frame state.
package dma_pkg;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_XSTEP  = 3'd1,
    CMD_YSTEP  = 3'd2,
    CMD_PSTEP  = 3'd3,
    CMD_RELOAD = 3'd4
  } adctl_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } ag_state_e;

endpackage

// File: rtl/dma_adctl_decode.sv
// Decodes the active-low adctlp* bus into a command enum; codes 5-7 decode
// to NOP with rsvd raised so callers can flag them.
module dma_adctl_decode
  import dma_pkg::*;
(
  input  logic       adctlp2b,
  input  logic       adctlp1b,
  input  logic       adctlp0b,
  output adctl_cmd_e cmd,
  output logic       rsvd
);

  logic [2:0] code;
  assign code = ~{adctlp2b, adctlp1b, adctlp0b};

  always_comb begin
    cmd  = CMD_NOP;
    rsvd = 1'b0;
    case (code)
      3'd0:    cmd  = CMD_NOP;
      3'd1:    cmd  = CMD_XSTEP;
      3'd2:    cmd  = CMD_YSTEP;
      3'd3:    cmd  = CMD_PSTEP;
      3'd4:    cmd  = CMD_RELOAD;
      default: rsvd = 1'b1;
    endcase
  end

endmodule

// File: rtl/dma_addr_gen.sv
// 2-D DMA address generator: steps row/column addresses on sequencer commands
// and returns registered xskip/yskip/page flags. DMA_ADDR_GEN_ERRCHK_EN enables err.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int AW = 16,
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_load,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW-1:0] cfg_stride,
  input  logic [XW-1:0] cfg_xcount,
  input  logic [YW-1:0] cfg_ycount,
  input  logic          adctlp0b,
  input  logic          adctlp1b,
  input  logic          adctlp2b,
  output logic [AW-1:0] addr,
  output logic          xskip,
  output logic          yskip,
  output logic          page,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] PMASK = {{(AW-PW){1'b0}}, {PW{1'b1}}};

  ag_state_e     state_q, state_d;
  adctl_cmd_e    cmd;
  logic          rsvd;
  logic          frame_end, do_ystep;
  logic [AW-1:0] addr_q, addr_d, row_base_q, row_base_d;
  logic [AW-1:0] base_q, base_d, stride_q, stride_d;
  logic [XW-1:0] x_q, x_d, xlast_q, xlast_d;
  logic [YW-1:0] y_q, y_d, ylast_q, ylast_d;
  logic          xskip_q, xskip_d, yskip_q, yskip_d, page_q, page_d;

  dma_adctl_decode u_dec (
    .adctlp2b (adctlp2b),
    .adctlp1b (adctlp1b),
    .adctlp0b (adctlp0b),
    .cmd      (cmd),
    .rsvd     (rsvd)
  );

  // Flags are registered, so the last-cell test uses the current _q flags.
  assign frame_end = (state_q == ST_ACTIVE) && xskip_q && yskip_q &&
                     (cmd == CMD_XSTEP || cmd == CMD_YSTEP);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cfg_load) state_d = ST_ACTIVE;
      ST_ACTIVE: if (frame_end) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_ACTIVE);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    addr_d     = addr_q;
    row_base_d = row_base_q;
    base_d     = base_q;
    stride_d   = stride_q;
    x_d        = x_q;
    y_d        = y_q;
    xlast_d    = xlast_q;
    ylast_d    = ylast_q;
    do_ystep   = 1'b0;
    if (state_q == ST_IDLE && cfg_load) begin
      base_d     = cfg_base;
      stride_d   = cfg_stride;
      xlast_d    = (cfg_xcount == '0) ? '0 : cfg_xcount - XW'(1);
      ylast_d    = (cfg_ycount == '0) ? '0 : cfg_ycount - YW'(1);
      addr_d     = cfg_base;
      row_base_d = cfg_base;
      x_d        = '0;
      y_d        = '0;
    end else if (state_q == ST_ACTIVE && !frame_end) begin
      case (cmd)
        CMD_XSTEP: begin
          if (xskip_q) do_ystep = 1'b1;
          else begin
            addr_d = addr_q + AW'(1);
            x_d    = x_q + XW'(1);
          end
        end
        CMD_YSTEP:  do_ystep = 1'b1;
        CMD_PSTEP:  addr_d = (addr_q | PMASK) + AW'(1);
        CMD_RELOAD: begin
          addr_d     = base_q;
          row_base_d = base_q;
          x_d        = '0;
          y_d        = '0;
        end
        default: ;
      endcase
      if (do_ystep) begin
        row_base_d = row_base_q + stride_q;
        addr_d     = row_base_q + stride_q;
        x_d        = '0;
        y_d        = y_q + YW'(1);
      end
    end
  end

  always_comb begin
    xskip_d = (state_d == ST_ACTIVE) && (x_d == xlast_d);
    yskip_d = (state_d == ST_ACTIVE) && (y_d == ylast_d);
    page_d  = (state_d == ST_ACTIVE) && (&addr_d[PW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      row_base_q <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      xlast_q    <= '0;
      ylast_q    <= '0;
      xskip_q    <= 1'b0;
      yskip_q    <= 1'b0;
      page_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xlast_q    <= xlast_d;
      ylast_q    <= ylast_d;
      xskip_q    <= xskip_d;
      yskip_q    <= yskip_d;
      page_q     <= page_d;
    end
  end

  assign addr  = addr_q;
  assign xskip = xskip_q;
  assign yskip = yskip_q;
  assign page  = page_q;

`ifdef DMA_ADDR_GEN_ERRCHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && cfg_load)        err_d = 1'b0;
    else if (state_q == ST_ACTIVE && rsvd)     err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_rsvd;
  assign unused_rsvd = rsvd;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dma_addr_gen.sv
// Directed, table-driven bench for dma_addr_gen (default parameters),
// plus a hand-written single-cell frame sequence for done-pulse width.
module tb_dma_addr_gen;

`ifdef DMA_ADDR_GEN_ERRCHK_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  localparam logic [2:0] NOP = 3'd0, XS = 3'd1, YS = 3'd2, PS = 3'd3, RL = 3'd4, R6 = 3'd6;

  logic        clk = 1'b0;
  logic        rst, cfg_load;
  logic [15:0] cfg_base, cfg_stride;
  logic [7:0]  cfg_xcount, cfg_ycount;
  logic        adctlp0b, adctlp1b, adctlp2b;
  logic [15:0] addr;
  logic        xskip, yskip, page, busy, done, err;

  always #5 clk = ~clk;

  dma_addr_gen dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_base(cfg_base),
    .cfg_stride(cfg_stride), .cfg_xcount(cfg_xcount), .cfg_ycount(cfg_ycount),
    .adctlp0b(adctlp0b), .adctlp1b(adctlp1b), .adctlp2b(adctlp2b),
    .addr(addr), .xskip(xskip), .yskip(yskip), .page(page),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    string       name;
    bit          rst, ld;
    logic [15:0] base, stride;
    logic [7:0]  xc, yc;
    logic [2:0]  code;
    bit          chk_addr;
    logic [15:0] addr;
    bit          xs, ys, pg, bz, dn, er;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0, n_bad = 0;

  task automatic v(input string n, input bit r, input bit l, input logic [15:0] b,
                   input logic [15:0] s, input logic [7:0] xc, input logic [7:0] yc,
                   input logic [2:0] c, input bit ca, input logic [15:0] a,
                   input bit xs, input bit ys, input bit pg, input bit bz,
                   input bit dn, input bit er);
    vec_t t;
    t.name = n; t.rst = r; t.ld = l; t.base = b; t.stride = s; t.xc = xc; t.yc = yc;
    t.code = c; t.chk_addr = ca; t.addr = a;
    t.xs = xs; t.ys = ys; t.pg = pg; t.bz = bz; t.dn = dn; t.er = er;
    vq.push_back(t);
  endtask

  task automatic c(input string n, input logic [2:0] cd, input bit ca, input logic [15:0] a,
                   input bit xs, input bit ys, input bit pg, input bit bz, input bit dn, input bit er);
    v(n, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0, 8'h0, cd, ca, a, xs, ys, pg, bz, dn, er);
  endtask

  task automatic ld(input string n, input logic [15:0] b, input logic [15:0] s,
                    input logic [7:0] xc, input logic [7:0] yc, input logic [15:0] a,
                    input bit xs, input bit ys, input bit pg, input bit er);
    v(n, 1'b0, 1'b1, b, s, xc, yc, NOP, 1'b1, a, xs, ys, pg, 1'b1, 1'b0, er);
  endtask

  task automatic r(input string n, input logic [2:0] cd);
    v(n, 1'b1, 1'b0, 16'h0, 16'h0, 8'h0, 8'h0, cd, 1'b1, 16'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive(input bit r_i, input bit l_i, input logic [15:0] b, input logic [15:0] s,
                       input logic [7:0] xc, input logic [7:0] yc, input logic [2:0] cd);
    rst = r_i; cfg_load = l_i; cfg_base = b; cfg_stride = s;
    cfg_xcount = xc; cfg_ycount = yc;
    {adctlp2b, adctlp1b, adctlp0b} = ~cd;
  endtask

  initial begin
    drive(1'b1, 1'b0, 16'h0, 16'h0, 8'h0, 8'h0, NOP);

    r("reset", NOP);
    // raster 3x2
    ld("rast_load", 16'h0100, 16'h0010, 8'd3, 8'd2, 16'h0100, 0, 0, 0, 0);
    c("rast_x1", XS, 1, 16'h0101, 0, 0, 0, 1, 0, 0);
    c("rast_x2", XS, 1, 16'h0102, 1, 0, 0, 1, 0, 0);
    c("rast_x3", XS, 1, 16'h0110, 0, 1, 0, 1, 0, 0);
    c("rast_x4", XS, 1, 16'h0111, 0, 1, 0, 1, 0, 0);
    c("rast_x5", XS, 1, 16'h0112, 1, 1, 0, 1, 0, 0);
    c("rast_done", XS, 0, 16'h0, 0, 0, 0, 0, 1, 0);
    c("rast_idle", NOP, 0, 16'h0, 0, 0, 0, 0, 0, 0);
    c("idle_xstep", XS, 0, 16'h0, 0, 0, 0, 0, 0, 0);
    // reload mid-row, cfg_load ignored while active
    ld("rl_load", 16'h0100, 16'h0010, 8'd3, 8'd2, 16'h0100, 0, 0, 0, 0);
    c("rl_x1", XS, 1, 16'h0101, 0, 0, 0, 1, 0, 0);
    c("rl_x2", XS, 1, 16'h0102, 1, 0, 0, 1, 0, 0);
    c("rl_x3", XS, 1, 16'h0110, 0, 1, 0, 1, 0, 0);
    c("rl_x4", XS, 1, 16'h0111, 0, 1, 0, 1, 0, 0);
    c("reload", RL, 1, 16'h0100, 0, 0, 0, 1, 0, 0);
    ld("ld_ignored", 16'h5000, 16'h0001, 8'd5, 8'd5, 16'h0100, 0, 0, 0, 0);
    c("post_reload", XS, 1, 16'h0101, 0, 0, 0, 1, 0, 0);
    r("rst_with_xstep", XS);
    c("no_done", NOP, 1, 16'h0, 0, 0, 0, 0, 0, 0);
    // page boundary
    ld("pg_load", 16'h00FE, 16'h0100, 8'd8, 8'd4, 16'h00FE, 0, 0, 0, 0);
    c("pg_xstep", XS, 1, 16'h00FF, 0, 0, 1, 1, 0, 0);
    c("pg_pstep_ff", PS, 1, 16'h0100, 0, 0, 0, 1, 0, 0);
    r("rst2", NOP);
    ld("p34_load", 16'h0034, 16'h0010, 8'd4, 8'd1, 16'h0034, 0, 1, 0, 0);
    c("p34_pstep", PS, 1, 16'h0100, 0, 1, 0, 1, 0, 0);
    r("rst3", NOP);
    // wrap, reserved code, err sticky across frame end
    ld("wrap_load", 16'hFFFE, 16'h0004, 8'd4, 8'd3, 16'hFFFE, 0, 0, 0, 0);
    c("wrap_ystep", YS, 1, 16'h0002, 0, 0, 0, 1, 0, 0);
    c("code6", R6, 1, 16'h0002, 0, 0, 0, 1, 0, E);
    c("w_ystep2", YS, 1, 16'h0006, 0, 1, 0, 1, 0, E);
    c("w_x1", XS, 1, 16'h0007, 0, 1, 0, 1, 0, E);
    c("w_x2", XS, 1, 16'h0008, 0, 1, 0, 1, 0, E);
    c("w_x3", XS, 1, 16'h0009, 1, 1, 0, 1, 0, E);
    c("w_done", XS, 0, 16'h0, 0, 0, 0, 0, 1, E);
    c("w_idle", NOP, 0, 16'h0, 0, 0, 0, 0, 0, E);
    // zero counts act as one; load clears err
    ld("zero_load", 16'h0200, 16'h0010, 8'd0, 8'd0, 16'h0200, 1, 1, 0, 0);
    c("zero_done", YS, 0, 16'h0, 0, 0, 0, 0, 1, 0);
    c("zero_idle", NOP, 0, 16'h0, 0, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].ld, vq[i].base, vq[i].stride, vq[i].xc, vq[i].yc, vq[i].code);
      @(posedge clk);
      #1;
      n_vec++;
      if ((vq[i].chk_addr && addr !== vq[i].addr) || xskip !== vq[i].xs ||
          yskip !== vq[i].ys || page !== vq[i].pg || busy !== vq[i].bz ||
          done !== vq[i].dn || err !== vq[i].er) begin
        n_bad++;
        $display("FAIL %s: got addr=%h xs=%b ys=%b pg=%b busy=%b done=%b err=%b, want addr=%h%s xs=%b ys=%b pg=%b busy=%b done=%b err=%b",
                 vq[i].name, addr, xskip, yskip, page, busy, done, err,
                 vq[i].addr, vq[i].chk_addr ? "" : "(any)",
                 vq[i].xs, vq[i].ys, vq[i].pg, vq[i].bz, vq[i].dn, vq[i].er);
      end
    end

    // single-cell frame: done must pulse exactly once and busy must drop
    begin
      int pulses = 0;
      drive(1'b0, 1'b1, 16'h0300, 16'h0001, 8'd1, 8'd1, NOP);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 16'h0, 16'h0, 8'h0, 8'h0, XS);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 16'h0, 16'h0, 8'h0, 8'h0, NOP);
      for (int k = 0; k < 10; k++) begin
        if (done === 1'b1) pulses++;
        @(posedge clk); #1;
      end
      n_vec++;
      if (pulses != 1 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL done_pulse_width: got pulses=%0d busy=%b, want pulses=1 busy=0", pulses, busy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_addr_gen.md
# dma_addr_gen

Two-dimensional DMA address generator that sits at the far end of the DMA control sequencer. Each cycle it takes the sequencer's active-low address-control code (`adctlp2b..adctlp0b`) and steps a row/column address. It returns the `xskip`, `yskip` and `page` status flags that the sequencer consumes to compute its next state. It owns the frame geometry registers and the current memory address.

## Interface
Parameters:
- `AW`, 16: address width
- `XW`, 8: column counter width
- `YW`, 8: row counter width
- `PW`, 8: page size is 2^PW words; `PW < AW`

Ports:
- `clk`  in  1: single clock. One clock; reset is synchronous and active-high.
- `rst`  in  1: synchronous, active-high reset
- `cfg_load`  in  1: latch the geometry and start a frame
- `cfg_base`  in  AW: frame start address
- `cfg_stride`  in  AW: row-to-row address increment
- `cfg_xcount`  in  XW: columns per row, value N means N columns; 0 is treated as 1
- `cfg_ycount`  in  YW: rows per frame; 0 is treated as 1
- `adctlp0b`, `adctlp1b`, `adctlp2b`  in  1 each: active-low command bits
- `addr`  out  AW: current address (registered)
- `xskip`  out  1: column counter at last column
- `yskip`  out  1: row counter at last row
- `page`  out  1: low PW bits of `addr` are all ones, so the next +1 crosses a page
- `busy`  out  1: frame active
- `done`  out  1: one-cycle pulse when the frame completes
- `err`  out  1: sticky illegal-command flag (see Configuration)

## Operation
- The command is `cmd = ~{adctlp2b, adctlp1b, adctlp0b}`. Codes:
  - 0 NOP
  - 1 XSTEP
  - 2 YSTEP
  - 3 PSTEP
  - 4 RELOAD
  - 5–7 reserved
- States: IDLE, ACTIVE, DONE.
  - IDLE → ACTIVE on `cfg_load`. This latches the config and sets `addr` = `row_base` = `cfg_base`, `x` = 0, `y` = 0.
  - ACTIVE → DONE on an XSTEP or YSTEP issued while `xskip` && `yskip`.
  - DONE → IDLE unconditionally after one cycle. `done` is high exactly in that cycle.
- XSTEP:
  - Not at the last column: `addr` += 1, `x` += 1.
  - At the last column: behaves as YSTEP.
- YSTEP: `x` = 0, `y` += 1, `row_base` += `cfg_stride`, `addr` = new `row_base`.
- PSTEP: `addr` = (`addr` | (2^PW − 1)) + 1. `x`, `y` and `row_base` are unchanged.
- RELOAD: `addr` = `row_base` = latched base, `x` = `y` = 0. Stays ACTIVE.
- Commands are ignored in IDLE and DONE. `cfg_load` is ignored while ACTIVE.
- Arithmetic: all address sums are modulo 2^AW; wrap is silent.
- Flags:
  - `xskip` = (`x` == xcount − 1)
  - `yskip` = (`y` == ycount − 1)
  - `page` = &`addr[PW-1:0]`
  - All three are registered alongside `addr`, `x` and `y`, so they always match the current `addr`.
  - All flags are forced to 0 outside ACTIVE.

## Timing
- Reset values: `addr` = 0, `xskip` = `yskip` = `page` = 0, `busy` = 0, `done` = 0, `err` = 0, state = IDLE.
- A command sampled at edge k is reflected in `addr` and the flags after edge k; latency is 1 cycle. This lets the sequencer see the updated flags for its next-state decision in cycle k+1.
- `busy` rises the cycle after `cfg_load` and falls in the DONE cycle.
- Reset mid-frame: the frame is abandoned and no `done` is generated.
- `rst` has priority over `cfg_load` and over any command in the same cycle.

## Configuration
- Macro: `DMA_ADDR_GEN_ERRCHK_EN`.
- Defined: a reserved code (5–7) while ACTIVE sets `err`. `err` stays set until `rst` or the next accepted `cfg_load`. The command itself acts as NOP.
- Undefined: reserved codes act as NOP, and `err` is tied to 0.

## Structure
- Shared package `dma_pkg`: the `adctl_cmd_e` enum (NOP, XSTEP, YSTEP, PSTEP, RELOAD) and the `ag_state_e` enum (IDLE, ACTIVE, DONE).
- Sub-module `dma_adctl_decode`: a combinational bus-to-enum decoder from `adctlp*b` to `adctl_cmd_e` plus a reserved flag. It is reused by the sequencer's checker.

## Test plan
- Raster: base = 0x0100, stride = 0x0010, xcount = 3, ycount = 2, then 6 XSTEPs.
  - `addr` sequence: 0x0101, 0x0102, 0x0110, 0x0111, 0x0112, then DONE.
  - `xskip` is high at 0x0102 and 0x0112; `yskip` is high from 0x0110.
  - One `done` pulse; `busy` = 0 after it.
- Page: PW = 8, base = 0x00FE, xcount = 8.
  - XSTEP gives `addr` = 0x00FF with `page` = 1.
  - PSTEP from 0x0034 gives 0x0100.
- RELOAD mid-row at `addr` = 0x0111 returns `addr` = 0x0100 with `x` = `y` = 0 and `busy` still 1.
- Wrap: base = 0xFFFE, stride = 0x0004, then YSTEP gives `addr` = 0x0002 with no error.
- Code 6 while ACTIVE:
  - With `DMA_ADDR_GEN_ERRCHK_EN`: `err` = 1 next cycle and `addr` is unchanged.
  - Without the macro: `err` stays 0.
- `rst` asserted in the same cycle as an XSTEP mid-frame: all outputs are 0 next cycle and no `done` occurs.
